switch_debouncer: RTL

- Conditions the raw `ui_in` switch bank before the seven-segment name display and its compare logic consume it.
- Per bit: two-flop synchroniser, then a tick-based stability filter. Produces a glitch-free level, plus single-cycle rise/fall pulses and a change strobe.
- The display's name-change detection then sees only clean transitions, never bounce, so its counter/digit restart fires once per real switch move.

---
 rtl/switch_debouncer.sv | 92 +++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Switch-bank conditioner: two-flop synchroniser plus tick-sampled stability filter
// per bit, producing clean levels and registered rise/fall/changed pulses.
module switch_debouncer #(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 5,
  parameter int CNT_W        = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             tick
);

  localparam int              CW       = $clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s;
  logic [CNT_W-1:0] prescale;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] db_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s  <= '0;
    end else begin
      s1 <= raw_in;
      s  <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (ena) begin
      if (prescale == PRE_LAST) prescale <= '0;
      else                      prescale <= prescale + CNT_W'(1);
    end
  end

  assign tick = ena && (prescale == PRE_LAST);

  // Any cycle where the synchronised bit agrees with the output restarts its count.
  always_comb begin
    db_next   = db_out;
    rise_next = '0;
    fall_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (s[i] == db_out[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          cnt_next[i]  = '0;
          db_next[i]   = s[i];
          rise_next[i] = s[i];
          fall_next[i] = ~s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_out  <= '0;
      rise    <= '0;
      fall    <= '0;
      changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      db_out  <= db_next;
      rise    <= rise_next;
      fall    <= fall_next;
      changed <= |(rise_next | fall_next);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

endmodule
